// File: rtl/noc_rx_mailbox.sv
// NoC receive mailbox: DEPTH-entry packet FIFO exposed as a 4-register Avalon-MM slave with level irq.
// Reads return data one cycle after the strobe; in_ready drops when full or during a flush write.
module noc_rx_mailbox #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_irq_en;
  logic          r_underflow;

  logic          w_rd;
  logic          w_wr;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_uf_set;
  logic          w_irq_en_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [EW-1:0] w_head;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_rd      = chipselect & read;
  assign w_wr      = chipselect & write;
  assign w_ctrl_wr = w_wr & (address == 2'd3);
  assign w_flush   = w_ctrl_wr & writedata[2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = (r_count < CW'(DEPTH)) & ~w_flush;
  assign w_push    = in_valid & in_ready;
  // An empty DATA read never pops, even if a push lands on the same edge.
  assign w_pop     = w_rd & (address == 2'd1) & ~w_empty;
  assign w_uf_set  = w_rd & (address == 2'd1) & w_empty;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_unused  = &{1'b0, writedata[31:3]};

  assign w_irq_en_nxt = w_ctrl_wr ? writedata[0] : r_irq_en;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_comb begin
    w_rdata = readdata;
    if (w_rd) begin
      case (address)
        2'd0:    w_rdata = w_empty ? 32'd0 : 32'(w_head[EW-1:DATA_W]);
        2'd1:    w_rdata = w_empty ? 32'd0 : 32'(w_head[DATA_W-1:0]);
        2'd2:    w_rdata = {20'd0, r_irq_en, r_underflow, w_full, w_empty, 8'(r_count)};
        default: w_rdata = {31'd0, r_irq_en};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_irq_en    <= 1'b0;
      r_underflow <= 1'b0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_irq_en    <= w_irq_en_nxt;
      r_underflow <= w_uf_set | (r_underflow & ~(w_ctrl_wr & writedata[1]));
      readdata    <= w_rdata;
      irq         <= w_irq_en_nxt & (w_count_nxt != '0);
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_addr, in_data};
  end

endmodule

// File: tb/tb_noc_rx_mailbox.sv
// Randomized bench for noc_rx_mailbox against a queue-based mailbox model, plus directed literal checks.
module tb_noc_rx_mailbox;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        in_valid;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic        in_ready;

  noc_rx_mailbox #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } pkt_t;

  pkt_t        q[$];
  bit          m_irq_en;
  bit          m_uf;
  bit          m_irq;
  logic [31:0] m_rd;
  int          checks = 0;
  int          errors = 0;
  bit          acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_irq_en = 0;
    m_uf     = 0;
    m_irq    = 0;
    m_rd     = 32'd0;
  endtask

  // Called at a negedge; drives one cycle of inputs and checks the DUT against the model.
  task automatic step(input bit v, input logic [7:0] a, input logic [31:0] d,
                      input bit cs, input bit r, input bit w,
                      input logic [1:0] ad, input logic [31:0] wd, output bit accepted);
    bit rd_s, wr_s, ctrl, flush, ready, push, pop, ufset;
    logic [31:0] nxt;
    pkt_t p;
    in_valid = v; in_addr = a; in_data = d;
    chipselect = cs; read = r; write = w; address = ad; writedata = wd;
    #1;
    rd_s  = cs && r;
    wr_s  = cs && w;
    ctrl  = wr_s && (ad == 2'd3);
    flush = ctrl && wd[2];
    ready = (q.size() < DEPTH) && !flush;
    chk("in_ready", {31'd0, in_ready}, {31'd0, ready});
    push = v && ready;
    accepted = push;
    nxt = m_rd; pop = 0; ufset = 0;
    if (rd_s) begin
      case (ad)
        2'd0: nxt = (q.size() != 0) ? {24'd0, q[0].a} : 32'd0;
        2'd1: begin
          if (q.size() != 0) begin nxt = q[0].d; pop = 1; end
          else begin nxt = 32'd0; ufset = 1; end
        end
        2'd2: nxt = {20'd0, m_irq_en, m_uf, (q.size() == DEPTH), (q.size() == 0), 8'(q.size())};
        default: nxt = {31'd0, m_irq_en};
      endcase
    end
    @(posedge clk);
    m_rd = nxt;
    if (ctrl) begin
      m_irq_en = wd[0];
      if (wd[1]) m_uf = 0;
    end
    if (ufset) m_uf = 1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin p.a = a; p.d = d; q.push_back(p); end
    end
    m_irq = m_irq_en && (q.size() != 0);
    @(negedge clk);
    chk("readdata", readdata, m_rd);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle();
    bit x;
    step(0, 8'd0, 32'd0, 0, 0, 0, 2'd0, 32'd0, x);
  endtask

  task automatic rdreg(input logic [1:0] ad);
    bit x;
    step(0, 8'd0, 32'd0, 1, 1, 0, ad, 32'd0, x);
  endtask

  task automatic wrctrl(input logic [31:0] wd);
    bit x;
    step(0, 8'd0, 32'd0, 1, 0, 1, 2'd3, wd, x);
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    bit x;
    step(1, a, d, 0, 0, 0, 2'd0, 32'd0, x);
    chk("push_accepted", {31'd0, x}, 32'd1);
  endtask

  initial begin
    bit          pend;
    logic [7:0]  pa;
    logic [31:0] pd, wd;
    reset_n = 0; in_valid = 0; in_addr = 0; in_data = 0;
    chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
    mreset();
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1;
    idle();
    rdreg(2'd2);
    chk("status_reset", readdata, 32'h100);

    push(8'h12, 32'hDEADBEEF);
    rdreg(2'd0);  chk("src", readdata, 32'h12);
    rdreg(2'd1);  chk("data", readdata, 32'hDEADBEEF);
    rdreg(2'd2);  chk("status_empty", readdata, 32'h100);

    for (int i = 1; i <= 4; i++) push(8'(i), 32'(i));
    idle();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rdreg(2'd2);  chk("status_full", readdata, 32'h204);
    step(1, 8'd5, 32'd5, 0, 0, 0, 2'd0, 32'd0, acc);
    chk("held_off", {31'd0, acc}, 32'd0);
    step(1, 8'd5, 32'd5, 1, 1, 0, 2'd1, 32'd0, acc);
    chk("pop_when_full", readdata, 32'd1);
    step(1, 8'd5, 32'd5, 0, 0, 0, 2'd0, 32'd0, acc);
    chk("fifth_accepted", {31'd0, acc}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      rdreg(2'd1);
      chk("wrap_order", readdata, 32'(i));
    end

    push(8'hA1, 32'h111);
    push(8'hA2, 32'h222);
    step(1, 8'hA3, 32'h333, 1, 1, 0, 2'd1, 32'd0, acc);
    chk("simul_oldest", readdata, 32'h111);
    rdreg(2'd2);  chk("simul_count", readdata, 32'h002);
    rdreg(2'd1);  chk("drain_b", readdata, 32'h222);
    rdreg(2'd1);  chk("drain_c", readdata, 32'h333);
    rdreg(2'd1);  chk("empty_read", readdata, 32'd0);
    rdreg(2'd2);  chk("underflow_set", readdata, 32'h500);
    wrctrl(32'h2);
    rdreg(2'd2);  chk("underflow_clr", readdata, 32'h100);

    wrctrl(32'h1);
    chk("irq_empty", {31'd0, irq}, 32'd0);
    push(8'h07, 32'h77);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rdreg(2'd1);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    push(8'h1, 32'h1); push(8'h2, 32'h2); push(8'h3, 32'h3);
    step(1, 8'h4, 32'h4, 1, 0, 1, 2'd3, 32'h5, acc);
    chk("flush_blocks", {31'd0, acc}, 32'd0);
    step(1, 8'h4, 32'h4, 1, 1, 0, 2'd2, 32'd0, acc);
    chk("status_flush", readdata, 32'h900);
    push(8'h5, 32'h5);
    chk("irq_two", {31'd0, irq}, 32'd1);
    reset_n = 0;
    mreset();
    #1;
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_rd", readdata, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1;
    rdreg(2'd2);  chk("midrst_status", readdata, 32'h100);

    pend = 0; pa = 0; pd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1; pa = 8'($urandom); pd = $urandom;
      end
      wd = $urandom;
      wd[2] = ($urandom_range(0, 15) == 0);
      step(pend, pa, pd, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, 2'($urandom), wd, acc);
      if (acc) pend = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_rx_mailbox.md
Name: noc_rx_mailbox

Overview:
Receive-side controller for the NoC input path of the Nios system. It accepts packets from the NoC, each an ADDR_W-bit source address plus a DATA_W-bit payload, using a valid/ready handshake. Packets are buffered in a DEPTH-entry FIFO. The block presents the FIFO to the Nios CPU as a 4-register Avalon-MM slave with fixed one-cycle read latency and a level interrupt.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
DATA_W, 32, payload width; maximum 32
ADDR_W, 8, NoC source-address width; maximum 16

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon register select
chipselect  in  1  Avalon slave select
read  in  1  Avalon read strobe; qualified by chipselect
write  in  1  Avalon write strobe; qualified by chipselect
writedata  in  32  Avalon write data
readdata  out  32  registered read data
irq  out  1  level interrupt to CPU
in_valid  in  1  NoC packet valid
in_addr  in  ADDR_W  NoC source address
in_data  in  DATA_W  NoC payload
in_ready  out  1  block can accept a packet this cycle

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on reset_n.
- Reset: FIFO empty, rd_ptr = wr_ptr = count = 0, readdata = 0, irq_en = 0, underflow = 0. Consequently irq = 0 and in_ready = 1.
- Strobes: rd = chipselect & read; wr = chipselect & write.
- Push: on a clock edge where in_valid & in_ready, {in_addr, in_data} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH) & ~flush_now, where flush_now = wr & (address == 3) & writedata[2]. in_ready is combinational; the sender holds in_valid, in_addr and in_data stable until accepted.
- Register map, reads (readdata updated at the edge where rd is sampled, visible the next cycle):
  0 SRC: zero-extended head address. No pop. Returns 0 if the FIFO is empty.
  1 DATA: zero-extended head payload, and pops the head (rd_ptr++, mod DEPTH). If empty, returns 0, no pop, and sets underflow.
  2 STATUS: bits[7:0] count, bit8 empty, bit9 full, bit10 underflow, bit11 irq_en. Remaining bits 0.
  3 CTRL: bit0 irq_en, all other bits 0.
- When rd = 0, readdata holds its last value.
- Register map, writes to address 3 (CTRL):
  - bit0 loads irq_en.
  - bit1 = 1 clears underflow.
  - bit2 = 1 flushes: rd_ptr = wr_ptr = count = 0.
  - Writes to addresses 0-2 are ignored.
- count update per edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Push and pop in the same cycle are legal at any count 0<count<DEPTH.
  - At count = DEPTH, push is impossible (in_ready = 0); a pop frees the slot for the following cycle.
  - At count = 0, a simultaneous push and DATA read is treated as an empty read: returns 0, sets underflow, and the pushed entry stays in the FIFO.
- Flush has priority over a pop in the same cycle; no push can coincide with a flush.
- Underflow is sticky; a set and a clear in the same cycle resolve to set.
- irq is registered: irq = irq_en & (count != 0), evaluated on next-state values, so it asserts the cycle after the push edge.
- Pointers are log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
- Reset asserted mid-transfer discards all FIFO contents immediately. No handshake completes while reset_n = 0 (in_ready is still 1, but no state updates).

Test Plan:
- Reset then idle: readdata=0, irq=0, in_ready=1; a STATUS read returns 0x100 (empty).
- Push (0x12, 0xDEADBEEF); read SRC -> 0x12; read DATA -> 0xDEADBEEF; read STATUS -> 0x100.
- Push 4 packets with data 1..4: in_ready drops after the 4th and STATUS = 0x204. A 5th in_valid is held off; after one DATA read (returns 1) it is accepted. Next reads return 2, 3, 4, 5 in order (wrap-around).
- With count=2, assert push and DATA read in the same cycle: count stays 2 and the oldest entry is returned. Separately, a DATA read on empty returns 0 and sets STATUS bit10; writing CTRL=0x2 clears it.
- Write CTRL=0x1 on an empty FIFO: irq=0. Push one packet: irq=1 the cycle after the push edge. A DATA read makes irq=0 one cycle later.
- With 3 entries, write CTRL=0x5 while in_valid=1: in_ready=0 that cycle, then STATUS reads 0x900 (empty, irq_en). Finally, assert reset_n=0 with 2 entries buffered: count=0 immediately and irq=0.
